// File: rtl/lsu_if.sv
// Load-store unit bus: core-side access signals, switch pins and the
// load/IO results returned by the unit.
interface lsu_if #(
    parameter int unsigned SW_W = 32
);
    logic [31:0]     i_lsu_addr;
    logic [31:0]     i_st_data;
    logic            i_lsu_wren;
    logic [2:0]      i_lsu_op;
    logic [SW_W-1:0] i_io_sw;
    logic [31:0]     o_ld_data;
    logic            o_misaligned;
    logic [31:0]     o_io_ledr;
    logic [31:0]     o_io_ledg;
    logic [31:0]     o_io_hex;

    modport master (
        output i_lsu_addr, i_st_data, i_lsu_wren, i_lsu_op, i_io_sw,
        input  o_ld_data, o_misaligned, o_io_ledr, o_io_ledg, o_io_hex
    );

    modport slave (
        input  i_lsu_addr, i_st_data, i_lsu_wren, i_lsu_op, i_io_sw,
        output o_ld_data, o_misaligned, o_io_ledr, o_io_ledg, o_io_hex
    );
endinterface

// File: rtl/lsu.sv
// Load-store unit: data memory plus memory-mapped LED/HEX registers and a
// synchronised switch input. Loads are combinational, stores land on the
// rising clock edge with byte-lane enables.
module lsu #(
    parameter int unsigned DMEM_WORDS = 512,
    parameter int unsigned SW_W       = 32
) (
    input logic i_clk,
    input logic i_reset,
    lsu_if.slave bus
);
    localparam int unsigned AW = $clog2(DMEM_WORDS);

    localparam logic [2:0] OP_B  = 3'b000;
    localparam logic [2:0] OP_H  = 3'b001;
    localparam logic [2:0] OP_W  = 3'b010;
    localparam logic [2:0] OP_BU = 3'b100;
    localparam logic [2:0] OP_HU = 3'b101;

    logic [31:0]     dmem [DMEM_WORDS];
    logic [31:0]     ledr, ledg, hex;
    logic [SW_W-1:0] sw_meta, sw_sync;
    logic [31:0]     sw_word;

    logic [29:0]     word_addr;
    logic [1:0]      lane;
    logic [AW-1:0]   dmem_idx;
    logic            sel_dmem, sel_ledr, sel_ledg, sel_hex, sel_sw, mapped;
    logic            misaligned;
    logic [31:0]     rd_word, rd_byte_sh, rd_half_sh, ld_data;
    logic [3:0]      be;
    logic [31:0]     wdata;
    logic            st_ok;

    function automatic logic [31:0] merge(input logic [31:0] old_w,
                                          input logic [31:0] new_w,
                                          input logic [3:0]  en);
        logic [31:0] r;
        r = old_w;
        for (int unsigned k = 0; k < 4; k++) begin
            if (en[k]) r[8*k +: 8] = new_w[8*k +: 8];
        end
        return r;
    endfunction

    assign word_addr = bus.i_lsu_addr[31:2];
    assign lane      = bus.i_lsu_addr[1:0];
    assign dmem_idx  = bus.i_lsu_addr[AW+1:2];

    // Full 32-bit address decode
    always_comb begin
        sel_dmem = (bus.i_lsu_addr[31:AW+2] == '0);
        sel_ledr = (word_addr == 30'h0400_0000);
        sel_ledg = (word_addr == 30'h0400_0400);
        sel_hex  = (word_addr == 30'h0400_0800);
        sel_sw   = (word_addr == 30'h0400_4000);
        mapped   = sel_dmem | sel_ledr | sel_ledg | sel_hex | sel_sw;
    end

    // Alignment check; undefined ops are treated as word accesses
    always_comb begin
        misaligned = 1'b0;
        case (bus.i_lsu_op)
            OP_B, OP_BU: misaligned = 1'b0;
            OP_H, OP_HU: misaligned = lane[0];
            default:     misaligned = (lane != 2'b00);
        endcase
        misaligned = misaligned & mapped;
    end

    // Zero-extend the synchronised switch value to a full word
    always_comb begin
        sw_word = '0;
        sw_word[SW_W-1:0] = sw_sync;
    end

    // Select the addressed word from memory or IO
    always_comb begin
        rd_word = '0;
        if (sel_dmem)      rd_word = dmem[dmem_idx];
        else if (sel_ledr) rd_word = ledr;
        else if (sel_ledg) rd_word = ledg;
        else if (sel_hex)  rd_word = hex;
        else if (sel_sw)   rd_word = sw_word;
    end

    assign rd_byte_sh = rd_word >> {lane, 3'b000};
    assign rd_half_sh = rd_word >> {lane[1], 4'b0000};

    // Lane extraction with sign/zero extension
    always_comb begin
        ld_data = '0;
        if (mapped && !misaligned) begin
            case (bus.i_lsu_op)
                OP_B:    ld_data = {{24{rd_byte_sh[7]}}, rd_byte_sh[7:0]};
                OP_BU:   ld_data = {24'h0, rd_byte_sh[7:0]};
                OP_H:    ld_data = {{16{rd_half_sh[15]}}, rd_half_sh[15:0]};
                OP_HU:   ld_data = {16'h0, rd_half_sh[15:0]};
                default: ld_data = rd_word;
            endcase
        end
    end

    // Store lane enables and lane-replicated write data
    always_comb begin
        be    = '0;
        wdata = bus.i_st_data;
        case (bus.i_lsu_op)
            OP_B: begin
                be    = 4'b0001 << lane;
                wdata = {4{bus.i_st_data[7:0]}};
            end
            OP_H: begin
                be    = lane[1] ? 4'b1100 : 4'b0011;
                wdata = {2{bus.i_st_data[15:0]}};
            end
            OP_W:    be = 4'b1111;
            default: be = '0;
        endcase
        st_ok = bus.i_lsu_wren && !misaligned && !i_reset && (be != '0);
    end

    // Data memory write; contents survive reset
    always_ff @(posedge i_clk) begin
        if (st_ok && sel_dmem) dmem[dmem_idx] <= merge(dmem[dmem_idx], wdata, be);
    end

    // IO output registers
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            ledr <= '0;
            ledg <= '0;
            hex  <= '0;
        end else begin
            if (st_ok && sel_ledr) ledr <= merge(ledr, wdata, be);
            if (st_ok && sel_ledg) ledg <= merge(ledg, wdata, be);
            if (st_ok && sel_hex)  hex  <= merge(hex, wdata, be);
        end
    end

    // Two-flop synchroniser for the switch pins
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= bus.i_io_sw;
            sw_sync <= sw_meta;
        end
    end

    assign bus.o_ld_data    = ld_data;
    assign bus.o_misaligned = misaligned;
    assign bus.o_io_ledr    = ledr;
    assign bus.o_io_ledg    = ledg;
    assign bus.o_io_hex     = hex;
endmodule

// File: tb/tb_lsu.sv
// Testbench for lsu: directed scenarios plus randomized traffic checked
// against a byte-addressed reference model.
module tb_lsu;
    localparam int unsigned DW  = 512;
    localparam int unsigned SWW = 32;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    lsu_if #(.SW_W(SWW)) bus();
    lsu #(.DMEM_WORDS(DW), .SW_W(SWW)) dut (.i_clk(clk), .i_reset(rst), .bus(bus));

    always #5 clk = ~clk;

    // Reference model state
    byte unsigned m_dm [4*DW];
    byte unsigned m_io [3][4];
    logic [31:0]  m_s1, m_s2;

    // -1 unmapped, 0 dmem, 1 ledr, 2 ledg, 3 hex, 4 switches
    function automatic int region(input logic [31:0] a);
        if (a < 4*DW) return 0;
        case (a & ~32'h3)
            32'h1000_0000: return 1;
            32'h1000_1000: return 2;
            32'h1000_2000: return 3;
            32'h1001_0000: return 4;
            default:       return -1;
        endcase
    endfunction

    function automatic int size_of(input logic [2:0] op);
        if (op == 3'd0 || op == 3'd4) return 1;
        if (op == 3'd1 || op == 3'd5) return 2;
        return 4;
    endfunction

    function automatic bit m_mis(input logic [31:0] a, input logic [2:0] op);
        if (region(a) < 0) return 1'b0;
        return (a % size_of(op)) != 0;
    endfunction

    function automatic byte unsigned m_byte(input int r, input logic [31:0] a);
        logic [31:0] sh;
        if (r == 0) return m_dm[a];
        if (r == 4) begin
            sh = m_s2 >> (8 * (a % 4));
            return sh[7:0];
        end
        return m_io[r-1][a % 4];
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] a, input logic [2:0] op);
        logic [31:0] v;
        int r, n;
        r = region(a);
        if (r < 0 || m_mis(a, op)) return 32'h0;
        n = size_of(op);
        v = 32'h0;
        for (int i = 0; i < n; i++) v = v | (32'(m_byte(r, a + 32'(i))) << (8 * i));
        if (op == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
        if (op == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    function automatic logic [31:0] io_word(input int k);
        return {m_io[k][3], m_io[k][2], m_io[k][1], m_io[k][0]};
    endfunction

    task automatic m_reset();
        for (int k = 0; k < 3; k++)
            for (int j = 0; j < 4; j++) m_io[k][j] = 8'h00;
        m_s1 = '0;
        m_s2 = '0;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] d,
                         input logic w, input logic [2:0] op);
        bus.i_lsu_addr = a;
        bus.i_st_data  = d;
        bus.i_lsu_wren = w;
        bus.i_lsu_op   = op;
    endtask

    // Advance one rising edge, update the model, return at the falling edge
    task automatic tick();
        int r, n;
        logic [31:0] a, d;
        @(posedge clk);
        a = bus.i_lsu_addr;
        d = bus.i_st_data;
        r = region(a);
        n = size_of(bus.i_lsu_op);
        if (!rst && bus.i_lsu_wren && bus.i_lsu_op <= 3'd2 && !m_mis(a, bus.i_lsu_op)
            && r >= 0 && r <= 3) begin
            for (int i = 0; i < n; i++) begin
                if (r == 0) m_dm[a + 32'(i)] = d[8*i +: 8];
                else        m_io[r-1][(a + 32'(i)) % 4] = d[8*i +: 8];
            end
        end
        if (rst) begin
            m_s1 = '0;
            m_s2 = '0;
        end else begin
            m_s2 = m_s1;
            m_s1 = bus.i_io_sw;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.i_io_sw = 32'hCAFE_F00D;
        m_reset();
        drive(32'h1000_0000, 32'hFFFF_FFFF, 1'b1, 3'd2);
        tick();
        tick();
        drive(32'h1001_0000, 32'h0, 1'b0, 3'd2);
        #1;
        checks++; if (bus.o_io_ledr !== 32'h0) begin errors++; $display("FAIL reset_ledr got=%h exp=%h", bus.o_io_ledr, 32'h0); end
        checks++; if (bus.o_io_ledg !== 32'h0) begin errors++; $display("FAIL reset_ledg got=%h exp=%h", bus.o_io_ledg, 32'h0); end
        checks++; if (bus.o_io_hex !== 32'h0) begin errors++; $display("FAIL reset_hex got=%h exp=%h", bus.o_io_hex, 32'h0); end
        checks++; if (bus.o_ld_data !== 32'h0) begin errors++; $display("FAIL reset_sw got=%h exp=%h", bus.o_ld_data, 32'h0); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_fill();
        for (int w = 0; w < int'(DW); w++) begin
            drive(32'(4 * w), $urandom, 1'b1, 3'd2);
            tick();
        end
    endtask

    task automatic test_directed();
        logic [31:0] exp;
        // word store, read-before-write, then visible next cycle
        drive(32'h10, 32'hDEAD_BEEF, 1'b1, 3'd2);
        exp = m_load(32'h10, 3'd2);
        #1;
        checks++; if (bus.o_ld_data !== exp) begin errors++; $display("FAIL rbw_old got=%h exp=%h", bus.o_ld_data, exp); end
        tick();
        drive(32'h10, 32'h0, 1'b0, 3'd2); #1;
        checks++; if (bus.o_ld_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_new got=%h exp=%h", bus.o_ld_data, 32'hDEAD_BEEF); end
        // byte store and sign/zero-extended byte loads
        drive(32'h13, 32'h0000_00AA, 1'b1, 3'd0);
        tick();
        drive(32'h13, 32'h0, 1'b0, 3'd0); #1;
        checks++; if (bus.o_ld_data !== 32'hFFFF_FFAA) begin errors++; $display("FAIL lb got=%h exp=%h", bus.o_ld_data, 32'hFFFF_FFAA); end
        drive(32'h13, 32'h0, 1'b0, 3'd4); #1;
        checks++; if (bus.o_ld_data !== 32'h0000_00AA) begin errors++; $display("FAIL lbu got=%h exp=%h", bus.o_ld_data, 32'h0000_00AA); end
        drive(32'h10, 32'h0, 1'b0, 3'd2); #1;
        checks++; if (bus.o_ld_data !== 32'hAAAD_BEEF) begin errors++; $display("FAIL lw_after_sb got=%h exp=%h", bus.o_ld_data, 32'hAAAD_BEEF); end
        // misaligned load and suppressed misaligned store
        drive(32'h11, 32'h0, 1'b0, 3'd1); #1;
        checks++; if (bus.o_misaligned !== 1'b1) begin errors++; $display("FAIL lh_mis_flag got=%b exp=1", bus.o_misaligned); end
        checks++; if (bus.o_ld_data !== 32'h0) begin errors++; $display("FAIL lh_mis_data got=%h exp=0", bus.o_ld_data); end
        drive(32'h12, 32'h1, 1'b1, 3'd2);
        tick();
        drive(32'h10, 32'h0, 1'b0, 3'd2); #1;
        checks++; if (bus.o_ld_data !== 32'hAAAD_BEEF) begin errors++; $display("FAIL sw_mis_dropped got=%h exp=%h", bus.o_ld_data, 32'hAAAD_BEEF); end
        // LED register lanes and asynchronous reset
        drive(32'h1000_0000, 32'h1234, 1'b1, 3'd2);
        tick();
        checks++; if (bus.o_io_ledr !== 32'h1234) begin errors++; $display("FAIL ledr_sw got=%h exp=%h", bus.o_io_ledr, 32'h1234); end
        drive(32'h1000_0002, 32'hFFFF, 1'b1, 3'd1);
        tick();
        checks++; if (bus.o_io_ledr !== 32'hFFFF_1234) begin errors++; $display("FAIL ledr_sh got=%h exp=%h", bus.o_io_ledr, 32'hFFFF_1234); end
        drive(32'h1000_0000, 32'hAAAA_5555, 1'b1, 3'd2);
        #2 rst = 1'b1;
        m_reset();
        #1;
        checks++; if (bus.o_io_ledr !== 32'h0) begin errors++; $display("FAIL ledr_async_rst got=%h exp=0", bus.o_io_ledr); end
        tick();
        rst = 1'b0;
        drive(32'h10, 32'h0, 1'b0, 3'd2); #1;
        checks++; if (bus.o_io_ledr !== 32'h0) begin errors++; $display("FAIL ledr_store_lost got=%h exp=0", bus.o_io_ledr); end
        checks++; if (bus.o_ld_data !== 32'hAAAD_BEEF) begin errors++; $display("FAIL dmem_keep got=%h exp=%h", bus.o_ld_data, 32'hAAAD_BEEF); end
        // switch synchroniser latency and read-only behaviour
        bus.i_io_sw = 32'h0;
        drive(32'h1001_0000, 32'h0, 1'b0, 3'd2);
        tick();
        tick();
        bus.i_io_sw = 32'h5A5; #1;
        checks++; if (bus.o_ld_data !== 32'h0) begin errors++; $display("FAIL sw_edge0 got=%h exp=0", bus.o_ld_data); end
        tick(); #1;
        checks++; if (bus.o_ld_data !== 32'h0) begin errors++; $display("FAIL sw_edge1 got=%h exp=0", bus.o_ld_data); end
        tick(); #1;
        checks++; if (bus.o_ld_data !== 32'h5A5) begin errors++; $display("FAIL sw_edge2 got=%h exp=%h", bus.o_ld_data, 32'h5A5); end
        drive(32'h1001_0000, 32'hFFFF_FFFF, 1'b1, 3'd2);
        tick();
        drive(32'h1001_0000, 32'h0, 1'b0, 3'd2); #1;
        checks++; if (bus.o_ld_data !== 32'h5A5) begin errors++; $display("FAIL sw_readonly got=%h exp=%h", bus.o_ld_data, 32'h5A5); end
        // unmapped addresses, including one past the end of DMEM
        drive(32'h5000_0000, 32'hFFFF_FFFF, 1'b1, 3'd2); #1;
        checks++; if (bus.o_ld_data !== 32'h0 || bus.o_misaligned !== 1'b0) begin errors++; $display("FAIL unmapped_hi got=%h/%b exp=0/0", bus.o_ld_data, bus.o_misaligned); end
        tick();
        drive(32'(4*DW), 32'hFFFF_FFFF, 1'b1, 3'd2); #1;
        checks++; if (bus.o_ld_data !== 32'h0 || bus.o_misaligned !== 1'b0) begin errors++; $display("FAIL unmapped_dmem_end got=%h/%b exp=0/0", bus.o_ld_data, bus.o_misaligned); end
        tick();
        drive(32'(4*DW - 4), 32'h0, 1'b0, 3'd2); #1;
        exp = m_load(32'(4*DW - 4), 3'd2);
        checks++; if (bus.o_ld_data !== exp) begin errors++; $display("FAIL dmem_last got=%h exp=%h", bus.o_ld_data, exp); end
        checks++; if (bus.o_io_ledr !== 32'h0 || bus.o_io_ledg !== 32'h0 || bus.o_io_hex !== 32'h0) begin errors++; $display("FAIL unmapped_io got=%h %h %h exp=0", bus.o_io_ledr, bus.o_io_ledg, bus.o_io_hex); end
    endtask

    task automatic test_random();
        logic [31:0] a, exp;
        logic [2:0]  op;
        logic        exp_mis;
        for (int it = 0; it < 1500; it++) begin
            if ($urandom_range(0, 7) == 0) bus.i_io_sw = $urandom;
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: a = 32'($urandom_range(0, 4*DW - 1));
                5: a = 32'h1000_0000 + 32'($urandom_range(0, 2)) * 32'h1000 + 32'($urandom_range(0, 3));
                6: a = 32'h1001_0000 + 32'($urandom_range(0, 3));
                7: begin
                    case ($urandom_range(0, 3))
                        0: a = 32'(4*DW) + 32'($urandom_range(0, 3));
                        1: a = 32'h1000_0004 + 32'($urandom_range(0, 3));
                        2: a = 32'h5000_0000 + 32'($urandom_range(0, 255));
                        default: a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
                    endcase
                end
                default: a = 32'(4*DW - 4) + 32'($urandom_range(0, 3));
            endcase
            op = 3'($urandom_range(0, 7));
            drive(a, $urandom, 1'($urandom_range(0, 1)), op);
            rst = ($urandom_range(0, 199) == 0);
            if (rst) m_reset();
            #1;
            exp     = m_load(a, op);
            exp_mis = m_mis(a, op);
            if (size_of(op) != 4 || op == 3'd2 || a[1:0] == 2'b00) begin
                checks++; if (bus.o_ld_data !== exp) begin errors++; $display("FAIL rnd_load a=%h op=%0d got=%h exp=%h", a, op, bus.o_ld_data, exp); end
                checks++; if (bus.o_misaligned !== exp_mis) begin errors++; $display("FAIL rnd_mis a=%h op=%0d got=%b exp=%b", a, op, bus.o_misaligned, exp_mis); end
            end
            tick();
            rst = 1'b0;
            checks++;
            if (bus.o_io_ledr !== io_word(0) || bus.o_io_ledg !== io_word(1) || bus.o_io_hex !== io_word(2)) begin
                errors++;
                $display("FAIL rnd_io got=%h %h %h exp=%h %h %h", bus.o_io_ledr, bus.o_io_ledg, bus.o_io_hex,
                         io_word(0), io_word(1), io_word(2));
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fill();
        test_directed();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
